tdm_demux: RTL and testbench

Time-division demultiplexer: the receive-side counterpart of the team's 2:1 select muxes. It takes a slot-serialised stream of words, one per slot and CHANNELS slots per frame, marked by a start-of-frame flag. Each slot is steered into its own channel register. Once a full frame is collected, all channels are presented in parallel with a one-cycle valid strobe. It sits at the far end of a TDM link, feeding per-channel consumers.

---
 rtl/tdm_demux.sv | 136 +++++++++++++
 tb/tb_tdm_demux.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// tdm_demux: receive-side time-division demultiplexer.
// Each slot word of a sof-marked frame is collected into a shadow register.
// When the last slot arrives, the whole frame is published on y with a
// one-cycle y_valid strobe. An early sof aborts the partial frame and
// pulses frame_err.
module tdm_demux #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  localparam int SW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      sof,
  output logic [CHANNELS*WIDTH-1:0] y,
  output logic                      y_valid,
  output logic [SW-1:0]             sel,
  output logic                      frame_err
);

  typedef enum logic {
    HUNT,
    COLLECT
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [SW-1:0]             r_sel;
  logic [SW-1:0]             w_sel_nxt;
  logic [WIDTH-1:0]          r_shadow [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] r_y;
  logic                      r_y_valid;
  logic                      r_frame_err;

  logic                      w_load_first;
  logic                      w_load_slot;
  logic                      w_complete;
  logic                      w_err;
  logic [CHANNELS*WIDTH-1:0] w_frame;

  // State and slot-index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Next-state, next-slot and per-word actions.
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_load_first = 1'b0;
    w_load_slot  = 1'b0;
    w_complete   = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      HUNT: begin
        // Words without sof are dropped while searching for frame start.
        if (din_valid && sof) begin
          w_load_first = 1'b1;
          w_sel_nxt    = SW'(1);
          w_state_nxt  = COLLECT;
        end
      end
      COLLECT: begin
        if (din_valid) begin
          if (sof) begin
            // Early sof: drop the partial frame and restart from slot 0.
            w_err        = 1'b1;
            w_load_first = 1'b1;
            w_sel_nxt    = SW'(1);
          end else if (r_sel == SW'(CHANNELS - 1)) begin
            w_complete  = 1'b1;
            w_sel_nxt   = '0;
            w_state_nxt = HUNT;
          end else begin
            w_load_slot = 1'b1;
            w_sel_nxt   = r_sel + SW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = HUNT;
        w_sel_nxt   = '0;
      end
    endcase
  end

  // Completed frame: collected slots plus the last slot taken straight from din.
  always_comb begin
    w_frame = '0;
    for (int unsigned c = 0; c < CHANNELS - 1; c++) begin
      w_frame[c*WIDTH +: WIDTH] = r_shadow[c];
    end
    w_frame[(CHANNELS-1)*WIDTH +: WIDTH] = din;
  end

  // Shadow slot capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        r_shadow[c] <= '0;
      end
    end else if (w_load_first) begin
      r_shadow[0] <= din;
    end else if (w_load_slot) begin
      r_shadow[r_sel] <= din;
    end
  end

  // Output frame register and single-cycle status strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y         <= '0;
      r_y_valid   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_y_valid   <= w_complete;
      r_frame_err <= w_err;
      if (w_complete) begin
        r_y <= w_frame;
      end
    end
  end

  assign y         = r_y;
  assign y_valid   = r_y_valid;
  assign frame_err = r_frame_err;
  assign sel       = r_sel;

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed vector table, hand-written reset/default-parameter
// sequences and randomized traffic checked against a frame-queue model.
module tb_tdm_demux;

  localparam int W = 8;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [W-1:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           sof = 1'b0;
  logic [C*W-1:0] y;
  logic           y_valid;
  logic           frame_err;
  logic [1:0]     sel;

  logic           s_din = 1'b0;
  logic           s_v = 1'b0;
  logic           s_sof = 1'b0;
  logic [1:0]     s_y;
  logic           s_yv;
  logic           s_err;
  logic           s_sel;

  tdm_demux #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
    .y(y), .y_valid(y_valid), .sel(sel), .frame_err(frame_err)
  );

  tdm_demux #(.WIDTH(1), .CHANNELS(2)) dut_small (
    .clk(clk), .rst(rst), .din(s_din), .din_valid(s_v), .sof(s_sof),
    .y(s_y), .y_valid(s_yv), .sel(s_sel), .frame_err(s_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: words of the frame being collected, in slot order.
  // An empty queue means no frame start has been seen (hunting).
  logic [W-1:0]   mq[$];
  logic [C*W-1:0] m_y = '0;
  bit             m_yv = 1'b0;
  bit             m_err = 1'b0;

  typedef struct {
    bit             v;
    bit             s;
    logic [W-1:0]   d;
    logic [C*W-1:0] ey;
    bit             eyv;
    bit             eerr;
    logic [1:0]     esel;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_y   = '0;
    m_yv  = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit s, input logic [W-1:0] d);
    m_yv  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (s) begin
        if (mq.size() > 0) m_err = 1'b1;
        mq.delete();
        mq.push_back(d);
      end else if (mq.size() > 0) begin
        mq.push_back(d);
        if (mq.size() == C) begin
          for (int c = 0; c < C; c++) m_y[c*W +: W] = mq[c];
          m_yv = 1'b1;
          mq.delete();
        end
      end
    end
  endtask

  // Apply one cycle of input, advance the model, sample 1 time unit after the edge.
  task automatic drive(input bit v, input bit s, input logic [W-1:0] d);
    din_valid = v;
    sof       = s;
    din       = d;
    model_step(v, s, d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_y"},   64'(y),         64'(m_y));
    chk({tag, "_yv"},  64'(y_valid),   64'(m_yv));
    chk({tag, "_err"}, 64'(frame_err), 64'(m_err));
    chk({tag, "_sel"}, 64'(sel),       64'(mq.size()));
    chk({tag, "_excl"}, 64'(y_valid & frame_err), 64'(0));
  endtask

  function automatic void add(input bit v, input bit s, input logic [W-1:0] d,
                              input logic [C*W-1:0] ey, input bit eyv,
                              input bit eerr, input logic [1:0] esel);
    tbl.push_back('{v, s, d, ey, eyv, eerr, esel});
  endfunction

  initial begin
    // Slot words with two idle cycles between each.
    add(1, 1, 8'hA1, 32'h0, 0, 0, 2'd1);
    add(0, 0, 8'h00, 32'h0, 0, 0, 2'd1);
    add(0, 0, 8'h00, 32'h0, 0, 0, 2'd1);
    add(1, 0, 8'hB2, 32'h0, 0, 0, 2'd2);
    add(0, 0, 8'h00, 32'h0, 0, 0, 2'd2);
    add(0, 0, 8'h00, 32'h0, 0, 0, 2'd2);
    add(1, 0, 8'hC3, 32'h0, 0, 0, 2'd3);
    add(0, 0, 8'h00, 32'h0, 0, 0, 2'd3);
    add(0, 0, 8'h00, 32'h0, 0, 0, 2'd3);
    add(1, 0, 8'hD4, 32'hD4C3B2A1, 1, 0, 2'd0);
    add(0, 0, 8'h00, 32'hD4C3B2A1, 0, 0, 2'd0);
    // Early sof aborts the partial frame; y holds until the next completion.
    add(1, 1, 8'h11, 32'hD4C3B2A1, 0, 0, 2'd1);
    add(1, 0, 8'h22, 32'hD4C3B2A1, 0, 0, 2'd2);
    add(1, 1, 8'h33, 32'hD4C3B2A1, 0, 1, 2'd1);
    add(1, 0, 8'h44, 32'hD4C3B2A1, 0, 0, 2'd2);
    add(1, 0, 8'h55, 32'hD4C3B2A1, 0, 0, 2'd3);
    add(1, 0, 8'h66, 32'h66554433, 1, 0, 2'd0);
    // Words before sync are dropped without error.
    add(1, 0, 8'h77, 32'h66554433, 0, 0, 2'd0);
    add(1, 0, 8'h88, 32'h66554433, 0, 0, 2'd0);
    add(1, 1, 8'h01, 32'h66554433, 0, 0, 2'd1);
    add(1, 0, 8'h02, 32'h66554433, 0, 0, 2'd2);
    add(1, 0, 8'h03, 32'h66554433, 0, 0, 2'd3);
    add(1, 0, 8'h04, 32'h04030201, 1, 0, 2'd0);
    // Back-to-back frames, din_valid held high.
    add(1, 1, 8'h10, 32'h04030201, 0, 0, 2'd1);
    add(1, 0, 8'h20, 32'h04030201, 0, 0, 2'd2);
    add(1, 0, 8'h30, 32'h04030201, 0, 0, 2'd3);
    add(1, 0, 8'h40, 32'h40302010, 1, 0, 2'd0);
    add(1, 1, 8'h50, 32'h40302010, 0, 0, 2'd1);
    add(1, 0, 8'h60, 32'h40302010, 0, 0, 2'd2);
    add(1, 0, 8'h70, 32'h40302010, 0, 0, 2'd3);
    add(1, 0, 8'h80, 32'h80706050, 1, 0, 2'd0);
    add(0, 0, 8'h00, 32'h80706050, 0, 0, 2'd0);

    // Reset state while rst is held.
    #2;
    chk("rst_y",   64'(y),         64'(0));
    chk("rst_yv",  64'(y_valid),   64'(0));
    chk("rst_err", 64'(frame_err), 64'(0));
    chk("rst_sel", 64'(sel),       64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Idle and unsynchronised words change nothing.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00);
      check_model("idle");
    end
    drive(1, 0, 8'h5A);
    check_model("nosof");

    // Directed vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d);
      chk($sformatf("vec%0d_y", i),   64'(y),         64'(tbl[i].ey));
      chk($sformatf("vec%0d_yv", i),  64'(y_valid),   64'(tbl[i].eyv));
      chk($sformatf("vec%0d_err", i), 64'(frame_err), 64'(tbl[i].eerr));
      chk($sformatf("vec%0d_sel", i), 64'(sel),       64'(tbl[i].esel));
    end

    // Asynchronous reset in the middle of a frame, between clock edges.
    drive(1, 1, 8'h91);
    drive(1, 0, 8'h92);
    chk("pre_rst_sel", 64'(sel), 64'(2));
    #3;
    rst = 1'b1;
    #1;
    chk("arst_y",   64'(y),         64'(0));
    chk("arst_yv",  64'(y_valid),   64'(0));
    chk("arst_err", 64'(frame_err), 64'(0));
    chk("arst_sel", 64'(sel),       64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 0, 8'h00);
    check_model("post_rst_idle");
    drive(1, 0, 8'h93);
    check_model("post_rst_nosof");
    drive(0, 0, 8'h00);
    check_model("post_rst_idle2");

    // Default parameters: two one-bit channels.
    s_v = 1'b1; s_sof = 1'b1; s_din = 1'b1;
    @(posedge clk);
    #1;
    chk("small_sel1", 64'(s_sel), 64'(1));
    chk("small_yv0",  64'(s_yv),  64'(0));
    s_sof = 1'b0; s_din = 1'b0;
    @(posedge clk);
    #1;
    chk("small_y",    64'(s_y),   64'(2'b01));
    chk("small_yv1",  64'(s_yv),  64'(1));
    chk("small_sel0", 64'(s_sel), 64'(0));
    chk("small_err",  64'(s_err), 64'(0));
    s_v = 1'b0;
    @(posedge clk);
    #1;
    chk("small_yv_off", 64'(s_yv), 64'(0));
    chk("small_y_hold", 64'(s_y),  64'(2'b01));

    // Randomized traffic against the frame-queue model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, W'($urandom));
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
